// File: rtl/aes_stream_packer_if.sv
// Signal bundle for the AES stream packer: descriptor channel, 128-bit block
// channel and the 32-bit word stream towards the AES controller input bus.
// master = descriptor/block source and word sink, slave = the packer.
interface aes_stream_packer_if;

  // descriptor channel
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_word;
  logic         cmd_key256;
  logic         cmd_has_iv;
  logic [255:0] cmd_key;
  logic [127:0] cmd_iv;

  // data block channel
  logic         blk_tvalid;
  logic         blk_tready;
  logic [127:0] blk_tdata;
  logic         blk_tlast;

  // output word stream
  logic         bus_tvalid;
  logic         bus_tready;
  logic [31:0]  bus_tdata;
  logic         bus_tlast;

  modport master (
    output cmd_valid, cmd_word, cmd_key256, cmd_has_iv, cmd_key, cmd_iv,
    input  cmd_ready,
    output blk_tvalid, blk_tdata, blk_tlast,
    input  blk_tready,
    input  bus_tvalid, bus_tdata, bus_tlast,
    output bus_tready
  );

  modport slave (
    input  cmd_valid, cmd_word, cmd_key256, cmd_has_iv, cmd_key, cmd_iv,
    output cmd_ready,
    input  blk_tvalid, blk_tdata, blk_tlast,
    output blk_tready,
    output bus_tvalid, bus_tdata, bus_tlast,
    input  bus_tready
  );

endinterface

// File: rtl/aes_stream_packer.sv
// AES command stream packer.
// Serialises one descriptor (cmd word, 128/256-bit key, optional IV) and the
// following 128-bit data blocks into a 32-bit word stream, most-significant
// word of each 128-bit block first, with tlast on the final data word.
// The output word is held in a register; a one-block holding buffer plus a
// bypass from blk_tdata keeps consecutive blocks free of bubble cycles.
module aes_stream_packer #(
  parameter int BUS_DATA_WIDTH = 32,   // fixed at 32
  parameter int BLK_WIDTH      = 128   // fixed at 128
) (
  input  logic              clk,
  input  logic              reset,
  aes_stream_packer_if.slave sp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_KEY_LO,
    S_KEY_HI,
    S_IV,
    S_DATA
  } state_e;

  state_e                      state_q;
  logic                        cmd_ready_q;
  logic                        key256_q;
  logic                        has_iv_q;
  logic [2*BLK_WIDTH-1:0]      key_q;
  logic [BLK_WIDTH-1:0]        iv_q;
  logic [BLK_WIDTH-1:0]        buf_q;
  logic                        buf_valid_q;
  logic                        buf_last_q;
  logic [1:0]                  word_idx_q;
  logic                        bus_tvalid_q;
  logic                        bus_tlast_q;
  logic [BUS_DATA_WIDTH-1:0]   bus_tdata_q;

  logic                        advance;
  logic                        hdr_last;
  logic                        blk_tready_c;
  logic                        blk_accept;
  logic [1:0]                  idx_next;
  logic [BLK_WIDTH-1:0]        hdr_blk;

  // 32-bit slice of a 128-bit block, index 0 = most-significant word.
  function automatic logic [BUS_DATA_WIDTH-1:0] word_of(
    input logic [BLK_WIDTH-1:0] blk,
    input logic [1:0]           idx
  );
    case (idx)
      2'd0:    word_of = blk[127:96];
      2'd1:    word_of = blk[95:64];
      2'd2:    word_of = blk[63:32];
      default: word_of = blk[31:0];
    endcase
  endfunction

  // Handshake qualifiers, header block selection and block-channel ready.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    advance      = bus_tvalid_q && sp.bus_tready;
    idx_next     = word_idx_q + 2'd1;
    hdr_last     = (state_q == S_IV) ||
                   (state_q == S_KEY_HI && !has_iv_q) ||
                   (state_q == S_KEY_LO && !key256_q && !has_iv_q);
    hdr_blk      = key_q[BLK_WIDTH-1:0];
    blk_tready_c = 1'b0;

    case (state_q)
      S_KEY_HI: hdr_blk = key_q[2*BLK_WIDTH-1:BLK_WIDTH];
      S_IV:     hdr_blk = iv_q;
      default:  ;
    endcase

    case (state_q)
      // The last header word is always valid, so its handshake is bus_tready.
      S_KEY_LO, S_KEY_HI, S_IV:
        blk_tready_c = hdr_last && (word_idx_q == 2'd3) && sp.bus_tready;
      // In DATA bus_tvalid mirrors buf_valid; refill when empty or when the
      // last word of the buffered block is leaving; stop after the final block.
      S_DATA:
        blk_tready_c = !(buf_valid_q && buf_last_q) &&
                       (!buf_valid_q || ((word_idx_q == 2'd3) && sp.bus_tready));
      default: ;
    endcase

    blk_accept = blk_tready_c && sp.blk_tvalid;
  end

  // Packet sequencer with registered output word, tvalid, tlast and cmd_ready.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: key/IV/buffer payload registers are not reset; they are always written before being read.
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      bus_tvalid_q <= 1'b0;
      bus_tdata_q  <= '0;
      bus_tlast_q  <= 1'b0;
      word_idx_q   <= 2'd0;
      buf_valid_q  <= 1'b0;
      buf_last_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sp.cmd_valid && cmd_ready_q) begin
            key256_q     <= sp.cmd_key256;
            has_iv_q     <= sp.cmd_has_iv;
            key_q        <= sp.cmd_key;
            iv_q         <= sp.cmd_iv;
            cmd_ready_q  <= 1'b0;
            state_q      <= S_CMD;
            word_idx_q   <= 2'd0;
            bus_tvalid_q <= 1'b1;
            bus_tdata_q  <= sp.cmd_word;
            bus_tlast_q  <= 1'b0;
          end else begin
            cmd_ready_q  <= 1'b1;
          end
        end

        S_CMD: begin
          if (advance) begin
            state_q     <= S_KEY_LO;
            word_idx_q  <= 2'd0;
            bus_tdata_q <= word_of(key_q[BLK_WIDTH-1:0], 2'd0);
          end
        end

        S_KEY_LO, S_KEY_HI, S_IV: begin
          if (advance) begin
            if (word_idx_q != 2'd3) begin
              word_idx_q  <= idx_next;
              bus_tdata_q <= word_of(hdr_blk, idx_next);
            end else if (state_q == S_KEY_LO && key256_q) begin
              state_q     <= S_KEY_HI;
              word_idx_q  <= 2'd0;
              bus_tdata_q <= word_of(key_q[2*BLK_WIDTH-1:BLK_WIDTH], 2'd0);
            end else if (state_q != S_IV && has_iv_q) begin
              state_q     <= S_IV;
              word_idx_q  <= 2'd0;
              bus_tdata_q <= word_of(iv_q, 2'd0);
            end else begin
              // Header done: present the first data word straight from the
              // block channel if a block is being accepted on this edge.
              state_q    <= S_DATA;
              word_idx_q <= 2'd0;
              if (blk_accept) begin
                buf_q        <= sp.blk_tdata;
                buf_valid_q  <= 1'b1;
                buf_last_q   <= sp.blk_tlast;
                bus_tdata_q  <= word_of(sp.blk_tdata, 2'd0);
              end else begin
                buf_valid_q  <= 1'b0;
                buf_last_q   <= 1'b0;
                bus_tvalid_q <= 1'b0;
              end
            end
          end
        end

        S_DATA: begin
          if (!buf_valid_q) begin
            // Underflow stall: wait for the next block.
            if (blk_accept) begin
              buf_q        <= sp.blk_tdata;
              buf_valid_q  <= 1'b1;
              buf_last_q   <= sp.blk_tlast;
              word_idx_q   <= 2'd0;
              bus_tvalid_q <= 1'b1;
              bus_tdata_q  <= word_of(sp.blk_tdata, 2'd0);
              bus_tlast_q  <= 1'b0;
            end
          end else if (advance) begin
            if (word_idx_q != 2'd3) begin
              word_idx_q  <= idx_next;
              bus_tdata_q <= word_of(buf_q, idx_next);
              bus_tlast_q <= buf_last_q && (idx_next == 2'd3);
            end else if (buf_last_q) begin
              // Final word of the packet has gone.
              state_q      <= S_IDLE;
              cmd_ready_q  <= 1'b1;
              bus_tvalid_q <= 1'b0;
              bus_tlast_q  <= 1'b0;
              buf_valid_q  <= 1'b0;
              buf_last_q   <= 1'b0;
            end else if (blk_accept) begin
              // Back-to-back block: bypass its first word into the output.
              buf_q        <= sp.blk_tdata;
              buf_last_q   <= sp.blk_tlast;
              word_idx_q   <= 2'd0;
              bus_tdata_q  <= word_of(sp.blk_tdata, 2'd0);
              bus_tlast_q  <= 1'b0;
            end else begin
              buf_valid_q  <= 1'b0;
              bus_tvalid_q <= 1'b0;
              bus_tlast_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q      <= S_IDLE;
          bus_tvalid_q <= 1'b0;
          bus_tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sp.cmd_ready  = cmd_ready_q;
  assign sp.blk_tready = blk_tready_c;
  assign sp.bus_tvalid = bus_tvalid_q;
  assign sp.bus_tdata  = bus_tdata_q;
  assign sp.bus_tlast  = bus_tlast_q;

endmodule

// File: doc/aes_stream_packer.md
Name: aes_stream_packer

Overview:
- Host-side transmitter that builds the 32-bit command stream consumed by the AES controller input bus.
- Takes one command descriptor (command word, key, optional IV) plus a stream of 128-bit data blocks.
- Serialises them into the word sequence: cmd word, key words, IV words, then data words, with tlast on the final word.
- Sits between a DMA/test source and the controller's in_bus_* interface, at full one-word-per-cycle throughput.

Parameters:
- BUS_DATA_WIDTH, 32, output word width; fixed at 32, other values unsupported.
- BLK_WIDTH, 128, data/IV/half-key block width; fixed at 128.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accepted when cmd_valid && cmd_ready.
- cmd_word  in  32  command word, transmitted verbatim.
- cmd_key256  in  1  1 = 256-bit key (8 key words), 0 = 128-bit key (4 words).
- cmd_has_iv  in  1  1 = send 4 IV words after the key.
- cmd_key  in  256  key; bits [127:0] sent first, [255:128] second (256-bit only).
- cmd_iv  in  128  IV.
- blk_tvalid  in  1  data block valid.
- blk_tready  out  1  data block accepted on blk_tvalid && blk_tready.
- blk_tdata  in  128  data block.
- blk_tlast  in  1  marks the final block of the command.
- bus_tvalid  out  1  output word valid.
- bus_tready  in  1  downstream ready.
- bus_tdata  out  32  output word.
- bus_tlast  out  1  last word of the packet.

Behaviour:
- Reset values: cmd_ready=0, blk_tready=0, bus_tvalid=0, bus_tdata=0, bus_tlast=0, state=IDLE. A mid-packet reset abandons the packet immediately; no tlast is emitted.
- States: IDLE, CMD, KEY_LO, KEY_HI, IV, DATA. A 2-bit word index selects the 32-bit slice.
- Word order within any 128-bit block: most-significant word first, i.e. [127:96], [95:64], [63:32], [31:0].
- IDLE: cmd_ready=1.
  - On descriptor handshake, latch all cmd_* fields into registers; cmd_ready drops next cycle.
  - Go to CMD, with bus_tvalid=1 and bus_tdata=cmd_word on the cycle after the handshake (latency 1).
- Output register rules:
  - A word advances only on bus_tvalid && bus_tready.
  - bus_tdata and bus_tlast must stay stable while bus_tvalid=1 and bus_tready=0.
  - No bubbles between words while bus_tready=1 and source data is available.
- Transitions:
  - CMD -> KEY_LO after 1 word.
  - KEY_LO -> KEY_HI after 4 words if key256, else -> IV if has_iv, else -> DATA.
  - KEY_HI -> IV if has_iv, else -> DATA, after 4 words.
  - IV -> DATA after 4 words.
- DATA uses a one-block holding register (buf, buf_valid, buf_last).
  - blk_tready = (state==DATA || key/IV phase ending) && (!buf_valid || (word_idx==3 && bus handshake)).
  - This allows back-to-back blocks with zero bubble cycles.
  - blk_tready is 0 once a block with blk_tlast has been accepted, until the next command.
  - If buf is empty in DATA, bus_tvalid=0; this is an underflow stall, not an error.
- bus_tlast=1 only on word 3 of the block accepted with blk_tlast=1.
  - After that handshake, return to IDLE; cmd_ready=1 the next cycle.
- Every command carries at least one data block. A descriptor alone never ends a packet.
- Packet length in words = 1 + 4·(1+key256) + 4·has_iv + 4·N_blocks.
- blk_tvalid asserted during IDLE/CMD/key/IV phases is ignored: blk_tready=0 until the final key/IV word handshake.

Test Plan:
- 128-bit key, no IV, 1 block; cmd_word=32'h0000_0102, key=128'h000102…0F, blk=128'h00112233_44556677_8899AABB_CCDDEEFF, bus_tready=1.
  - Expect 9 words on consecutive cycles: 0x00000102, 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, then 0x00112233…0xCCDDEEFF.
  - tlast only on 0xCCDDEEFF.
- 256-bit key + IV + 3 blocks, continuous blk_tvalid.
  - Expect 1+8+4+12=25 words.
  - Key words [127:0] precede [255:128].
  - No bubble cycles between blocks.
  - tlast only on word 25.
- Backpressure: bus_tready toggles 1,0,0,1 repeatedly.
  - bus_tdata/bus_tlast are held stable during every stall.
  - Word sequence is identical to the tready=1 run.
- Source underflow: blk_tvalid drops for 5 cycles between blocks.
  - bus_tvalid=0 during the gap.
  - Resumes with the first word of the next block.
  - No duplicated or lost words.
- Reset asserted after word 6 of a 13-word packet.
  - All outputs return to reset values next cycle, with no tlast.
  - A new command then produces a complete correct packet.
- Back-to-back commands: second descriptor held valid during the first packet.
  - cmd_ready=0 until the cycle after the first tlast handshake.
  - The second packet's cmd word follows with at most 2 idle cycles.
